// File: rtl/ao_ch_spi_ctrl.sv
// Analog-output channel SPI sequencer.
// Writes a 16-bit code to the DA converter (32-bit header + code), waits a
// chip-select gap, then reads the value back from the AD converter and
// compares it with the written code (LSB excluded). All pin outputs are
// registered; one always_ff carries the FSM, the counters and the outputs.
module ao_ch_spi_ctrl #(
    parameter int          CLK_DIV = 4,              // clk cycles per SCLK half-period (even, >= 2)
    parameter logic [31:0] DA_HDR  = 32'h5500_0001,  // DA frame header, MSB first
    parameter logic [7:0]  AD_CMD  = 8'h58,          // AD readback command, MSB first
    parameter int          CS_GAP  = 8               // cycles with both CS high between frames (>= 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_ao_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rb_data,
    output logic        o_rb_err,
    output logic        o_da_spi_clk,
    output logic        o_da_spi_cs,
    output logic        o_da_spi_mosi,
    output logic        o_ad_spi_clk,
    output logic        o_ad_spi_cs,
    output logic        o_ad_spi_mosi,
    input  logic        i_ad_spi_miso
);

    // Counter compare points inside a state. One SCLK period is 2*CLK_DIV
    // cycles: cycles 0..CLK_DIV-1 low, CLK_DIV..2*CLK_DIV-1 high.
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);      // last low cycle / last setup-hold cycle
    localparam logic [15:0] PER_LAST  = 16'(2 * CLK_DIV - 1);  // last high cycle of a period
    localparam logic [15:0] MID_LOW   = 16'(CLK_DIV / 2 - 1);  // MOSI updates on the following cycle
    localparam logic [15:0] RISE_CYC  = 16'(CLK_DIV);          // cycle in which SCLK is high for the first time
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    localparam logic [5:0] DA_PER_LAST = 6'd47;  // 48 periods: header + code
    localparam logic [5:0] AD_PER_LAST = 6'd23;  // 24 periods: 8 command + 16 readback
    localparam logic [5:0] AD_RB_FIRST = 6'd8;   // first readback period (0-based)

    typedef enum logic [2:0] {
        S_IDLE,
        S_DA_SETUP,
        S_DA_SHIFT,
        S_DA_HOLD,
        S_GAP,
        S_AD_SETUP,
        S_AD_SHIFT,
        S_AD_HOLD
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;        // cycle counter within the current state / SCLK period
    logic [15:0] cnt_d;
    logic [5:0]  per_q;        // SCLK period index within a shift state
    logic [47:0] da_sr_q;      // outgoing DA frame, MSB leaves first
    logic [7:0]  ad_sr_q;      // outgoing AD command, zeros shift in behind it
    logic [15:0] rb_sr_q;      // incoming readback bits
    logic [14:0] code_q;       // latched code bits [15:1]; the LSB never takes part in the compare

    logic        busy_q;
    logic        done_q;
    logic [15:0] rb_data_q;
    logic        rb_err_q;
    logic        da_clk_q;
    logic        da_cs_q;
    logic        da_mosi_q;
    logic        ad_clk_q;
    logic        ad_cs_q;
    logic        ad_mosi_q;

    // Default counter advance; states that finish a phase override it with zero.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
    end

    // Sequencer: state, counters, shift registers and registered pin outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            da_sr_q   <= '0;
            ad_sr_q   <= '0;
            rb_sr_q   <= '0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rb_data_q <= '0;
            rb_err_q  <= 1'b0;
            da_clk_q  <= 1'b0;
            da_cs_q   <= 1'b1;
            da_mosi_q <= 1'b0;
            ad_clk_q  <= 1'b0;
            ad_cs_q   <= 1'b1;
            ad_mosi_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        code_q  <= i_ao_data[15:1];
                        da_sr_q <= {DA_HDR, i_ao_data};
                        ad_sr_q <= AD_CMD;
                        rb_sr_q <= '0;
                        busy_q  <= 1'b1;
                        da_cs_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DA_SETUP;
                    end
                end

                S_DA_SETUP: begin
                    cnt_q <= cnt_d;
                    // First bit goes out half a low phase after CS falls.
                    if (cnt_q == MID_LOW) begin
                        da_mosi_q <= da_sr_q[47];
                        da_sr_q   <= {da_sr_q[46:0], 1'b0};
                    end
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        per_q   <= '0;
                        state_q <= S_DA_SHIFT;
                    end
                end

                S_DA_SHIFT: begin
                    cnt_q <= cnt_d;
                    // Period 0 already carries the bit presented during setup.
                    if (cnt_q == MID_LOW && per_q != 6'd0) begin
                        da_mosi_q <= da_sr_q[47];
                        da_sr_q   <= {da_sr_q[46:0], 1'b0};
                    end
                    if (cnt_q == HALF_LAST) begin
                        da_clk_q <= 1'b1;
                    end
                    if (cnt_q == PER_LAST) begin
                        da_clk_q <= 1'b0;
                        cnt_q    <= '0;
                        if (per_q == DA_PER_LAST) begin
                            state_q <= S_DA_HOLD;
                        end else begin
                            per_q <= per_q + 6'd1;
                        end
                    end
                end

                S_DA_HOLD: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == HALF_LAST) begin
                        da_cs_q   <= 1'b1;
                        da_mosi_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_GAP;
                    end
                end

                S_GAP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == GAP_LAST) begin
                        ad_cs_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_AD_SETUP;
                    end
                end

                S_AD_SETUP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == MID_LOW) begin
                        ad_mosi_q <= ad_sr_q[7];
                        ad_sr_q   <= {ad_sr_q[6:0], 1'b0};
                    end
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        per_q   <= '0;
                        state_q <= S_AD_SHIFT;
                    end
                end

                S_AD_SHIFT: begin
                    cnt_q <= cnt_d;
                    // After the 8 command bits the register holds zeros, so MOSI
                    // drops to 0 for the readback periods without extra logic.
                    if (cnt_q == MID_LOW && per_q != 6'd0) begin
                        ad_mosi_q <= ad_sr_q[7];
                        ad_sr_q   <= {ad_sr_q[6:0], 1'b0};
                    end
                    if (cnt_q == HALF_LAST) begin
                        ad_clk_q <= 1'b1;
                    end
                    // MISO is taken in the cycle where SCLK is first seen high.
                    if (cnt_q == RISE_CYC && per_q >= AD_RB_FIRST) begin
                        rb_sr_q <= {rb_sr_q[14:0], i_ad_spi_miso};
                    end
                    if (cnt_q == PER_LAST) begin
                        ad_clk_q <= 1'b0;
                        cnt_q    <= '0;
                        if (per_q == AD_PER_LAST) begin
                            state_q <= S_AD_HOLD;
                        end else begin
                            per_q <= per_q + 6'd1;
                        end
                    end
                end

                S_AD_HOLD: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == HALF_LAST) begin
                        ad_cs_q   <= 1'b1;
                        ad_mosi_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        rb_data_q <= rb_sr_q;
                        rb_err_q  <= (rb_sr_q[15:1] != code_q);
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_rb_data     = rb_data_q;
    assign o_rb_err      = rb_err_q;
    assign o_da_spi_clk  = da_clk_q;
    assign o_da_spi_cs   = da_cs_q;
    assign o_da_spi_mosi = da_mosi_q;
    assign o_ad_spi_clk  = ad_clk_q;
    assign o_ad_spi_cs   = ad_cs_q;
    assign o_ad_spi_mosi = ad_mosi_q;

endmodule

// File: tb/tb_ao_ch_spi_ctrl.sv
// Testbench for ao_ch_spi_ctrl: an AO channel model captures the DA frame and
// AD command from the pins, answers the readback, and checks pin timing.
module tb_ao_ch_spi_ctrl;

    localparam int          H    = 4;
    localparam int          GAP  = 8;
    localparam logic [31:0] HDR  = 32'h5500_0001;
    localparam logic [7:0]  CMD  = 8'h58;
    localparam int          LAT  = 148 * H + GAP + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ao_data = '0;
    logic        busy, done, rb_err;
    logic [15:0] rb_data;
    logic        da_clk, da_cs, da_mosi, ad_clk, ad_cs, ad_mosi;
    logic        miso = 1'b0;

    always #5 clk = ~clk;

    ao_ch_spi_ctrl #(
        .CLK_DIV(H), .DA_HDR(HDR), .AD_CMD(CMD), .CS_GAP(GAP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ao_data(ao_data),
        .o_busy(busy), .o_done(done), .o_rb_data(rb_data), .o_rb_err(rb_err),
        .o_da_spi_clk(da_clk), .o_da_spi_cs(da_cs), .o_da_spi_mosi(da_mosi),
        .o_ad_spi_clk(ad_clk), .o_ad_spi_cs(ad_cs), .o_ad_spi_mosi(ad_mosi),
        .i_ad_spi_miso(miso)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- AO channel model / pin monitor ----------------
    logic        force_en  = 1'b0;
    logic [15:0] force_val = '0;
    logic [15:0] ret_val   = '0;
    logic [47:0] da_bits   = '0;
    logic [7:0]  ad_bits   = '0;
    int          ad_rises  = 0;
    int          viol      = 0;
    int          done_cnt  = 0;
    int          gap_cnt   = 0;
    int          last_gap  = -1;
    int          da_since = 0, ad_since = 0, da_high = 0, ad_high = 0;
    bit          da_fell = 0, ad_fell = 0;
    logic        p_da_cs = 1'b1, p_da_clk = 1'b0, p_da_mosi = 1'b0;
    logic        p_ad_cs = 1'b1, p_ad_clk = 1'b0, p_ad_mosi = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!da_cs && !ad_cs) viol++;

        // DA port
        if (da_cs) begin
            if (da_clk || da_mosi) viol++;
            if (!p_da_cs) gap_cnt = 0; else gap_cnt++;
        end else if (p_da_cs) begin
            da_bits = '0; da_since = 0; da_high = 0; da_fell = 0;
            if (da_clk || da_mosi) viol++;
        end else begin
            if (!da_clk && p_da_clk) begin
                if (da_high != H) viol++;
                da_since = 0; da_high = 0; da_fell = 1;
            end else begin
                da_since++;
            end
            if (da_clk && !p_da_clk) begin
                da_bits = {da_bits[46:0], da_mosi};
                if (da_fell && da_since != H) viol++;
            end
            if (da_clk) da_high++;
            if (da_mosi != p_da_mosi && (da_clk || da_since != H / 2)) viol++;
        end

        // AD port
        if (ad_cs) begin
            if (ad_clk || ad_mosi) viol++;
            miso = 1'b0;
        end else begin
            if (p_ad_cs) begin
                last_gap = gap_cnt;
                ret_val  = force_en ? force_val : da_bits[15:0];
                ad_bits = '0; ad_rises = 0; ad_since = 0; ad_high = 0; ad_fell = 0;
                if (ad_clk || ad_mosi) viol++;
            end else begin
                if (!ad_clk && p_ad_clk) begin
                    if (ad_high != H) viol++;
                    ad_since = 0; ad_high = 0; ad_fell = 1;
                end else begin
                    ad_since++;
                end
                if (ad_clk && !p_ad_clk) begin
                    if (ad_rises < 8) ad_bits = {ad_bits[6:0], ad_mosi};
                    else if (ad_mosi) viol++;
                    ad_rises++;
                    if (ad_fell && ad_since != H) viol++;
                end
                if (ad_clk) ad_high++;
                if (ad_mosi != p_ad_mosi && (ad_clk || ad_since != H / 2)) viol++;
            end
            // Readback bit for period p is presented while SCLK is low.
            if (!ad_clk) begin
                if (ad_rises >= 8 && ad_rises < 24) miso = ret_val[23 - ad_rises];
                else miso = 1'b0;
            end
        end

        p_da_cs = da_cs; p_da_clk = da_clk; p_da_mosi = da_mosi;
        p_ad_cs = ad_cs; p_ad_clk = ad_clk; p_ad_mosi = ad_mosi;
    end

    // ---------------- stimulus helpers ----------------
    logic first_busy, first_da_cs;

    // mode 0: plain; 1: extra start at n=10 and data change at n=50; 2: reset at n=100.
    // Returns at the negedge of the o_done cycle (lat = cycles after acceptance),
    // or for mode 2 at the negedge just after the reset edge. lat=-1 on timeout.
    task automatic do_txn(input logic [15:0] code, input int mode, output int lat);
        lat = -1;
        start = 1'b1;
        ao_data = code;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                first_busy  = busy;
                first_da_cs = da_cs;
            end
            if (done && mode != 2) begin
                lat = n;
                start = 1'b0;
                return;
            end
            start = 1'b0;
            if (mode == 1 && n == 10) begin start = 1'b1; ao_data = 16'hFFFF; end
            if (mode == 1 && n == 50) ao_data = 16'h1234;
            if (mode == 2 && n == 100) rst = 1'b1;
            if (mode == 2 && n == 101) begin
                rst = 1'b0;
                lat = n;
                return;
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Expected results derive from the code written and what the model returns.
    task automatic txn_checks(input logic [15:0] code, input logic [15:0] exp_rb, input int lat);
        logic exp_err;
        exp_err = (exp_rb[15:1] != code[15:1]);
        $display("[TB] txn code=%04h rb=%04h err=%0b lat=%0d (exp rb=%04h err=%0b lat=%0d)",
                 code, rb_data, rb_err, lat, exp_rb, exp_err, LAT);
        check("latency", lat, LAT);
        check("da_frame", da_bits, {HDR, code});
        check("ad_cmd", ad_bits, CMD);
        check("rb_data", rb_data, exp_rb);
        check("rb_err", rb_err, exp_err);
        check("busy_at_done", busy, 1'b0);
        check("cs_gap", last_gap, GAP);
        check("pin_timing_viol", viol, 0);
    endtask

    initial begin
        int lat;
        int dc0;
        logic [15:0] code, exp_rb;

        // Reset state
        idle(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rb_data", rb_data, 16'h0);
        check("rst_rb_err", rb_err, 1'b0);
        check("rst_da_cs", da_cs, 1'b1);
        check("rst_ad_cs", ad_cs, 1'b1);
        check("rst_da_clk", da_clk, 1'b0);
        check("rst_ad_clk", ad_clk, 1'b0);
        check("rst_da_mosi", da_mosi, 1'b0);
        check("rst_ad_mosi", ad_mosi, 1'b0);
        rst = 1'b0;
        idle(2);

        // 1: matching readback
        do_txn(16'hA5A4, 0, lat);
        txn_checks(16'hA5A4, 16'hA5A4, lat);
        idle(5);
        check("rb_hold", rb_data, 16'hA5A4);

        // 2: forced readback of zero
        force_en = 1'b1; force_val = 16'h0000;
        do_txn(16'h8000, 0, lat);
        txn_checks(16'h8000, 16'h0000, lat);
        idle(3);

        // 3: only the LSB differs
        force_val = 16'h1234;
        do_txn(16'h1235, 0, lat);
        txn_checks(16'h1235, 16'h1234, lat);
        force_en = 1'b0;
        idle(3);

        // 4: start while busy and data change after acceptance are ignored
        dc0 = done_cnt;
        do_txn(16'h0F0E, 1, lat);
        txn_checks(16'h0F0E, 16'h0F0E, lat);
        idle(700);
        check("single_done", done_cnt - dc0, 1);

        // 5: reset during DA shift
        dc0 = done_cnt;
        do_txn(16'h3C3C, 2, lat);
        $display("[TB] txn code=3c3c reset at cycle 100");
        check("mrst_da_cs", da_cs, 1'b1);
        check("mrst_da_clk", da_clk, 1'b0);
        check("mrst_da_mosi", da_mosi, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_rb_data", rb_data, 16'h0);
        idle(700);
        check("mrst_no_done", done_cnt - dc0, 0);
        do_txn(16'h6789, 0, lat);
        txn_checks(16'h6789, 16'h6789, lat);
        idle(2);

        // 6: back-to-back, start in the o_done cycle
        do_txn(16'h1357, 0, lat);
        txn_checks(16'h1357, 16'h1357, lat);
        do_txn(16'hFEDC, 0, lat);
        check("b2b_busy_next", first_busy, 1'b1);
        check("b2b_da_cs_next", first_da_cs, 1'b0);
        txn_checks(16'hFEDC, 16'hFEDC, lat);
        idle(4);

        // Random codes with optional single-bit readback corruption
        for (int i = 0; i < 8; i++) begin
            code = 16'($urandom);
            force_en = 1'($urandom_range(0, 1));
            force_val = code ^ (16'h1 << $urandom_range(0, 15));
            exp_rb = force_en ? force_val : code;
            do_txn(code, 0, lat);
            txn_checks(code, exp_rb, lat);
            idle($urandom_range(1, 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
